// File: rtl/fu_md_iter.sv
// rtl/fu_md_iter.sv - iterative RV M-extension multiply/divide unit with fast paths
module fu_md_iter #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 4,
  parameter int DIV_BITS = 1,
  parameter int TAG_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             prv_valid,
  output logic             prv_ready,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [TAG_W-1:0] tag_in,
  output logic             nxt_valid,
  input  logic             nxt_ready,
  output logic [XLEN-1:0]  out_value,
  output logic [TAG_W-1:0] out_tag
);

  localparam int N_MUL = XLEN / MUL_BITS;
  localparam int N_DIV = XLEN / DIV_BITS;
  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(N_MUL - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(N_DIV - 1);

  generate
    if ((XLEN % MUL_BITS) != 0 || (DIV_BITS != 1 && DIV_BITS != 2) || (XLEN % DIV_BITS) != 0) begin : g_bad_param
      $error("fu_md_iter: MUL_BITS and DIV_BITS must divide XLEN, DIV_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                state, state_nxt;
  logic                  accept;
  logic [2:0]            op_q;
  logic [XLEN-1:0]       a_abs, b_abs;
  logic                  a_neg, b_neg;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      last_cnt;
  // Multiply: {high partial sum, remaining multiplier bits}; divide: {remainder, quotient/dividend}
  logic [2*XLEN-1:0]     acc;

  // Accept-time operand decode
  logic                  is_div, a_sgn, b_sgn, in_a_neg, in_b_neg;
  logic [XLEN-1:0]       in_a_abs, in_b_abs;
  logic                  div_zero, div_ovf, fast;
  logic [XLEN-1:0]       fast_value;

  // Operand signedness, magnitudes and the divide special cases
  always_comb begin
    is_div     = op[2];
    a_sgn      = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    b_sgn      = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    in_a_neg   = a_sgn && rs1[XLEN-1];
    in_b_neg   = b_sgn && rs2[XLEN-1];
    in_a_abs   = in_a_neg ? -rs1 : rs1;
    in_b_abs   = in_b_neg ? -rs2 : rs2;
    div_zero   = is_div && (rs2 == '0);
    div_ovf    = is_div && !op[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    fast       = div_zero || div_ovf;
    fast_value = '0;
    if (div_zero) fast_value = op[1] ? rs1 : '1;
    else          fast_value = op[1] ? '0 : rs1;
  end

  // Next state and handshake outputs; flush overrides everything
  always_comb begin
    state_nxt = state;
    nxt_valid = (state == DONE);
    prv_ready = !flush && ((state == IDLE) || ((state == DONE) && nxt_ready));
    accept    = prv_valid && prv_ready;
    last_cnt  = op_q[2] ? DIV_LAST : MUL_LAST;
    case (state)
      IDLE: if (accept) state_nxt = fast ? DONE : CALC;
      CALC: if (cnt == last_cnt) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (nxt_ready) state_nxt = accept ? (fast ? DONE : CALC) : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // One multiply step: add |a| times the low MUL_BITS multiplier digit into the high half
  logic [XLEN+MUL_BITS-1:0] partial, mul_sum;
  logic [2*XLEN-1:0]        mul_step;

  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (acc[i]) partial = partial + ({{MUL_BITS{1'b0}}, a_abs} << i);
    end
    mul_sum = {{MUL_BITS{1'b0}}, acc[2*XLEN-1:XLEN]} + partial;
  end

  generate
    if (MUL_BITS < XLEN) begin : g_mul_shift
      assign mul_step = {mul_sum, acc[XLEN-1:MUL_BITS]};
    end else begin : g_mul_whole
      assign mul_step = mul_sum;
    end
  endgenerate

  // DIV_BITS restoring division steps: shift the pair left, subtract the divisor if it fits
  logic [2*XLEN-1:0] div_step;
  logic [XLEN:0]     r_ext, diff;

  always_comb begin
    div_step = acc;
    r_ext    = '0;
    diff     = '0;
    for (int k = 0; k < DIV_BITS; k++) begin
      r_ext    = div_step[2*XLEN-1:XLEN-1];
      diff     = r_ext - {1'b0, b_abs};
      div_step = {div_step[2*XLEN-2:0], 1'b0};
      if (!diff[XLEN]) begin
        div_step[2*XLEN-1:XLEN] = diff[XLEN-1:0];
        div_step[0]             = 1'b1;
      end
    end
  end

  // Sign correction and half/quotient/remainder selection for the FIX cycle
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo, rem, fix_value;

  always_comb begin
    prod_s    = (a_neg ^ b_neg) ? -acc : acc;
    quo       = acc[XLEN-1:0];
    rem       = acc[2*XLEN-1:XLEN];
    fix_value = '0;
    if (op_q[2]) begin
      if (op_q[1]) fix_value = a_neg ? -rem : rem;
      else         fix_value = (a_neg ^ b_neg) ? -quo : quo;
    end else begin
      fix_value = (op_q[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end
  end

  // Datapath registers: load on accept, iterate in CALC, publish the result in FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      a_abs     <= '0;
      b_abs     <= '0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      out_value <= '0;
      out_tag   <= '0;
    end else if (accept) begin
      op_q    <= op;
      out_tag <= tag_in;
      a_abs   <= in_a_abs;
      b_abs   <= in_b_abs;
      a_neg   <= in_a_neg;
      b_neg   <= in_b_neg;
      cnt     <= '0;
      acc     <= is_div ? {{XLEN{1'b0}}, in_a_abs} : {{XLEN{1'b0}}, in_b_abs};
      if (fast) out_value <= fast_value;
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      acc <= op_q[2] ? div_step : mul_step;
    end else if (state == FIX) begin
      out_value <= fix_value;
    end
  end

endmodule

// File: tb/tb_fu_md_iter.sv
// tb/tb_fu_md_iter.sv - randomized and directed bench for fu_md_iter against a behavioural model
module tb_fu_md_iter;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        prv_valid;
  logic        prv_ready;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic [15:0] tag_in;
  logic        nxt_valid;
  logic        nxt_ready;
  logic [31:0] out_value;
  logic [15:0] out_tag;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  fu_md_iter #(.XLEN(32), .MUL_BITS(4), .DIV_BITS(1), .TAG_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .prv_valid(prv_valid), .prv_ready(prv_ready),
    .op(op), .rs1(rs1), .rs2(rs2), .tag_in(tag_in),
    .nxt_valid(nxt_valid), .nxt_ready(nxt_ready),
    .out_value(out_value), .out_tag(out_tag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Architectural result of an RV M instruction, straight from the ISA definition
  function automatic logic [31:0] exp_fn(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub;
    logic [63:0]        p;
    int                 ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    case (o)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycles from the accept edge to the first presented result
  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (!o[2]) return 32 / 4 + 2;
    if (b == 0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 32 + 2;
  endfunction

  // Reference model and per-cycle compare of all outputs
  logic        pend = 1'b0;
  int          due  = 0;
  logic [31:0] m_val = '0;
  logic [15:0] m_tag = '0;
  logic        exp_nv, exp_rdy;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
        chk("reset_nxt_valid", 64'(nxt_valid), 64'(0));
      end else begin
        exp_nv = pend && (cyc >= due);
        chk("nxt_valid", 64'(nxt_valid), 64'(exp_nv));
        if (exp_nv) begin
          chk("out_value", 64'(out_value), 64'(m_val));
          chk("out_tag", 64'(out_tag), 64'(m_tag));
        end
        exp_rdy = !flush && (!pend || (exp_nv && nxt_ready));
        chk("prv_ready", 64'(prv_ready), 64'(exp_rdy));
        if (flush || (exp_nv && nxt_ready)) pend = 1'b0;
        if (prv_valid && exp_rdy) begin
          pend  = 1'b1;
          m_val = exp_fn(op, rs1, rs2);
          m_tag = tag_in;
          due   = cyc + exp_lat(op, rs1, rs2);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [15:0] t);
    int n;
    n = 0;
    op = o; rs1 = a; rs2 = b; tag_in = t; prv_valid = 1'b1;
    #1;
    while (!prv_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("issue_timeout", 64'(n), 64'(0));
    @(posedge clk); #1;
    prv_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!nxt_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [15:0] t, input logic [31:0] exp, input int lat_exp);
    int lat;
    issue(o, a, b, t);
    wait_valid(lat);
    chk({name, "_latency"}, 64'(lat), 64'(lat_exp));
    chk({name, "_value"}, 64'(out_value), 64'(exp));
    chk({name, "_tag"}, 64'(out_tag), 64'(t));
    chk({name, "_model"}, 64'(exp_fn(o, a, b)), 64'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] v0;
    logic [15:0] t0;
    logic        seen;
    rst_n = 1'b0; flush = 1'b0; prv_valid = 1'b0; nxt_ready = 1'b1;
    op = '0; rs1 = '0; rs2 = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_value", 64'(out_value), 64'(0));
    chk("reset_out_tag", 64'(out_tag), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", 64'(prv_ready), 64'(1));
    @(posedge clk); #1;

    run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 16'hA001, 32'hFFFF_FFEB, 10);
    run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 16'hA002, 32'h4000_0000, 10);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 16'hA003, 32'hFFFF_FFFF, 10);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 16'hA004, 32'hFFFF_FFFE, 10);
    run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         16'hA005, 32'hFFFF_FFFD, 34);
    run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         16'hA006, 32'hFFFF_FFFF, 34);
    run_op("divu",   3'd5, 32'hFFFF_FFFF,  32'd2,         16'hA007, 32'h7FFF_FFFF, 34);
    run_op("div0",   3'd4, 32'd5,          32'd0,         16'hA008, 32'hFFFF_FFFF, 1);
    run_op("remu0",  3'd7, 32'd5,          32'd0,         16'hA009, 32'd5,         1);
    run_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 16'hA00A, 32'h8000_0000, 1);
    run_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 16'hA00B, 32'h0,         1);

    // Backpressure: result held, then back-to-back issue in the handshake cycle
    nxt_ready = 1'b0;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 16'h1111);
    wait_valid(lat);
    v0 = out_value; t0 = out_tag;
    chk("bp_value", 64'(v0), 64'(32'hFFFF_FFEB));
    chk("bp_tag", 64'(t0), 64'(16'h1111));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_value", 64'(out_value), 64'(32'hFFFF_FFEB));
      chk("bp_hold_tag", 64'(out_tag), 64'(16'h1111));
      chk("bp_hold_ready", 64'(prv_ready), 64'(0));
    end
    op = 3'd3; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; tag_in = 16'h2222; prv_valid = 1'b1;
    nxt_ready = 1'b1;
    #1;
    chk("b2b_ready", 64'(prv_ready), 64'(1));
    @(posedge clk); #1;
    prv_valid = 1'b0;
    wait_valid(lat);
    chk("b2b_latency", 64'(lat), 64'(10));
    chk("b2b_value", 64'(out_value), 64'(32'hFFFF_FFFE));
    chk("b2b_tag", 64'(out_tag), 64'(16'h2222));
    @(posedge clk); #1;

    // Flush on the 10th CALC cycle of a divide
    issue(3'd4, 32'd100, 32'd7, 16'h3333);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    #1;
    chk("flush_blocks_ready", 64'(prv_ready), 64'(0));
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("flush_ready_next", 64'(prv_ready), 64'(1));
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (nxt_valid) seen = 1'b1; end
    chk("flush_no_result", 64'(seen), 64'(0));

    // Flush together with an offer: not accepted
    flush = 1'b1; prv_valid = 1'b1; op = 3'd4; rs1 = 32'd9; rs2 = 32'd0; tag_in = 16'h4444;
    #1;
    chk("flush_offer_ready", 64'(prv_ready), 64'(0));
    @(posedge clk); #1;
    flush = 1'b0; prv_valid = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (nxt_valid) seen = 1'b1; end
    chk("flush_offer_dropped", 64'(seen), 64'(0));

    // Reset mid-multiply, and reset while a result is presented
    issue(3'd0, 32'd3, 32'd5, 16'h5555);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(nxt_valid), 64'(0));
    chk("rst_mid_value", 64'(out_value), 64'(0));
    chk("rst_mid_tag", 64'(out_tag), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    nxt_ready = 1'b0;
    issue(3'd0, 32'd6, 32'd7, 16'h6666);
    wait_valid(lat);
    chk("rst_done_pre_valid", 64'(nxt_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_done_valid", 64'(nxt_valid), 64'(0));
    chk("rst_done_value", 64'(out_value), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    nxt_ready = 1'b1;
    run_op("post_rst_mul", 3'd0, 32'd12345, 32'd1000, 16'h7777, 32'd12345000, 10);

    // Randomized traffic with random backpressure and occasional flush
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [31:0] a, b;
      r = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      if (r == 0) b = 32'd0;
      if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (r == 2) b = $urandom_range(1, 15);
      if (r == 3) a = $urandom_range(0, 100);
      op        = 3'($urandom_range(0, 7));
      rs1       = a;
      rs2       = b;
      tag_in    = 16'($urandom);
      prv_valid = ($urandom_range(0, 9) < 7);
      nxt_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 2);
      @(posedge clk); #1;
    end
    prv_valid = 1'b0; flush = 1'b0; nxt_ready = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("drain_idle", 64'(nxt_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
